layer_stream_ctrl: RTL and testbench

//  Sequences one fully-connected layer of Neuron_* instances.
//  - On start, reads the layer input vector from a sync-read input buffer.
//  - Broadcasts it to all neurons as one contiguous valid burst.
//  - Captures each neuron's result on its outvalid pulse.
//  - Streams the collected results out over a valid/ready port for the next layer.

---
 rtl/layer_stream_ctrl.sv | 168 ++++++++++++++++
 tb/tb_layer_stream_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_stream_ctrl.sv
// Sequencer for one fully-connected layer: streams the input vector to all neurons,
// collects each neuron's first result, then drains results over a valid/ready port.
// Optional WAIT timeout is enabled by defining LAYER_CTRL_TIMEOUT_EN.
module layer_stream_ctrl #(
  parameter int unsigned NUM_INPUTS     = 784,
  parameter int unsigned NUM_NEURONS    = 30,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned IN_AW  = $clog2(NUM_INPUTS),
  localparam int unsigned OUT_IW = $clog2(NUM_NEURONS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [IN_AW-1:0]                  in_raddr,
  input  logic [DATA_WIDTH-1:0]             in_rdata,
  output logic [DATA_WIDTH-1:0]             nrn_data,
  output logic                              nrn_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] nrn_out,
  input  logic [NUM_NEURONS-1:0]            nrn_outvalid,
  output logic [DATA_WIDTH-1:0]             res_data,
  output logic [OUT_IW-1:0]                 res_idx,
  output logic                              res_valid,
  input  logic                              res_ready
);

  typedef enum logic [1:0] {StIdle, StStream, StWait, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [IN_AW-1:0]        addr_q, addr_d;
  logic [OUT_IW-1:0]       idx_q, idx_d;
  logic [NUM_NEURONS-1:0]  flags_q, flags_d;
  logic [DATA_WIDTH-1:0]   res_reg [NUM_NEURONS];
  logic                    valid_q;
  logic                    done_q, done_d;
  logic                    capture_en;
  logic                    all_set;
  logic                    timeout_hit;

  assign capture_en = (state_q == StStream) || (state_q == StWait);

  always_comb begin
    flags_d = flags_q;
    if (capture_en) begin
      flags_d = flags_q | nrn_outvalid;
    end
    if ((state_q == StIdle) && start) begin
      flags_d = '0;
    end
  end

  // Uses this cycle's captures so the last response moves to DRAIN on the next edge.
  assign all_set = &flags_d;

`ifdef LAYER_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wait_cnt_q;
  logic          err_q;

  assign timeout_hit = (state_q == StWait) && !all_set &&
                       (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == StWait) ? wait_cnt_q + 1'b1 : '0;
      err_q      <= timeout_hit;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StStream;
          addr_d  = '0;
        end
      end
      StStream: begin
        if (addr_q == IN_AW'(NUM_INPUTS - 1)) begin
          state_d = StWait;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StWait: begin
        if (all_set) begin
          state_d = StDrain;
          idx_d   = '0;
        end else if (timeout_hit) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StDrain: begin
        if (res_ready) begin
          if (idx_q == OUT_IW'(NUM_NEURONS - 1)) begin
            state_d = StIdle;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      idx_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      flags_q <= flags_d;
      valid_q <= (state_q == StStream);
      done_q  <= done_d;
    end
  end

  // First pulse per neuron wins; later pulses are dropped by the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        res_reg[k] <= '0;
      end
    end else if (capture_en) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        if (nrn_outvalid[k] && !flags_q[k]) begin
          res_reg[k] <= nrn_out[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign in_raddr  = addr_q;
  assign nrn_valid = valid_q;
  assign nrn_data  = valid_q ? in_rdata : '0;
  assign res_valid = (state_q == StDrain);
  assign res_idx   = (state_q == StDrain) ? idx_q : '0;
  assign res_data  = (state_q == StDrain) ? res_reg[idx_q] : '0;

endmodule

// File: tb/tb_layer_stream_ctrl.sv
// Scoreboard bench for layer_stream_ctrl with a 4-input, 3-neuron layer.
module tb_layer_stream_ctrl;
  localparam int NI = 4;
  localparam int NN = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, err;
  logic [1:0]    in_raddr;
  logic [DW-1:0] in_rdata;
  logic [DW-1:0] nrn_data;
  logic          nrn_valid;
  logic [NN*DW-1:0] nrn_out;
  logic [NN-1:0] nrn_outvalid;
  logic [DW-1:0] res_data;
  logic [1:0]    res_idx;
  logic          res_valid;
  logic          res_ready;

  layer_stream_ctrl #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .in_raddr(in_raddr), .in_rdata(in_rdata), .nrn_data(nrn_data), .nrn_valid(nrn_valid),
    .nrn_out(nrn_out), .nrn_outvalid(nrn_outvalid), .res_data(res_data), .res_idx(res_idx),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [NI];
  always @(posedge clk) in_rdata <= mem[in_raddr];

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] burst_q [$];
  logic [31:0]   res_q [$];
  int            ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // res_ready changes away from the negedge sampling point.
  initial begin
    int cnt = 0;
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 0) res_ready = 1'b1;
      else begin
        case (cnt % 4)
          0: res_ready = 1'b1;
          1: res_ready = 1'b0;
          2: res_ready = 1'b0;
          default: res_ready = 1'b1;
        endcase
        cnt++;
      end
    end
  end

  // Monitor: burst data, result handshakes and stall stability.
  initial begin
    logic          stall_pending = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic [1:0]    held_idx = '0;
    logic [31:0]   e;
    forever begin
      @(negedge clk);
      if (nrn_valid) begin
        if (burst_q.size() == 0) check("burst_extra", 32'(nrn_valid), 32'd0);
        else check("burst_data", 32'(nrn_data), 32'(burst_q.pop_front()));
      end
      if (stall_pending) begin
        check("stall_valid", 32'(res_valid), 32'd1);
        check("stall_data", 32'(res_data), 32'(held_data));
        check("stall_idx", 32'(res_idx), 32'(held_idx));
      end
      stall_pending = 1'b0;
      if (res_valid) begin
        if (res_ready) begin
          if (res_q.size() == 0) check("res_extra", 32'(res_valid), 32'd0);
          else begin
            e = res_q.pop_front();
            check("res_idx", 32'(res_idx), 32'(e[17:16]));
            check("res_data", 32'(res_data), 32'(e[15:0]));
          end
        end else begin
          stall_pending = 1'b1;
          held_data = res_data;
          held_idx = res_idx;
        end
      end
    end
  end

  task automatic push_burst();
    for (int i = 0; i < NI; i++) burst_q.push_back(mem[i]);
  endtask

  task automatic push_res(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2);
    res_q.push_back({14'd0, 2'd0, v0});
    res_q.push_back({14'd0, 2'd1, v1});
    res_q.push_back({14'd0, 2'd2, v2});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one cycle of outvalid pulses, then clears them.
  task automatic pulse(input logic [NN-1:0] mask, input logic [15:0] v0,
                       input logic [15:0] v1, input logic [15:0] v2);
    nrn_out = {v2, v1, v0};
    nrn_outvalid = mask;
    @(negedge clk);
    nrn_outvalid = '0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_burst_end();
    bit seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (nrn_valid) seen = 1;
      else if (seen) return;
      @(negedge clk);
    end
    check("burst_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input logic exp_err);
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        check("done_err", 32'(err), 32'(exp_err));
        check("done_busy", 32'(busy), 32'd0);
        check("res_q_empty", 32'(res_q.size()), 32'd0);
        @(negedge clk);
        check("done_1cycle", 32'(done), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
        return;
      end
      @(negedge clk);
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    nrn_out = '0;
    nrn_outvalid = '0;
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
    idle(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_nrn_valid", 32'(nrn_valid), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_raddr", 32'(in_raddr), 32'd0);
    rst = 1'b0;
    idle(1);

    // Burst of 4 addresses, responses at offsets 3,5,4, start during WAIT ignored.
    push_burst();
    push_res(16'h0011, 16'h0022, 16'h0033);
    start_pulse();
    for (int i = 0; i < NI; i++) begin
      check("stream_raddr", 32'(in_raddr), 32'(i));
      check("stream_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    wait_burst_end();
    start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(2);
    pulse(3'b001, 16'h0011, 16'h0, 16'h0);
    pulse(3'b100, 16'h0011, 16'h0, 16'h0033);
    pulse(3'b010, 16'h0011, 16'h0022, 16'h0033);
    wait_done(1'b0);

    // All three pulse together; neuron 1 pulses again with 0xFFFF.
    push_burst();
    push_res(16'h00A1, 16'h00B2, 16'h00C3);
    start_pulse();
    wait_burst_end();
    pulse(3'b111, 16'h00A1, 16'h00B2, 16'h00C3);
    pulse(3'b010, 16'h00A1, 16'hFFFF, 16'h00C3);
    wait_done(1'b0);

    // Repeat pulse on neuron 1 while the others are still outstanding.
    push_burst();
    push_res(16'h0005, 16'h0022, 16'h0007);
    start_pulse();
    wait_burst_end();
    pulse(3'b010, 16'h0, 16'h0022, 16'h0);
    pulse(3'b010, 16'h0, 16'hFFFF, 16'h0);
    pulse(3'b101, 16'h0005, 16'hFFFF, 16'h0007);
    wait_done(1'b0);

    // Backpressure during DRAIN.
    ready_mode = 1;
    push_burst();
    push_res(16'h0100, 16'h0200, 16'h0300);
    start_pulse();
    wait_burst_end();
    pulse(3'b111, 16'h0100, 16'h0200, 16'h0300);
    wait_done(1'b0);
    ready_mode = 0;
    idle(2);

    // Reset mid-STREAM: only the first sample is broadcast before reset lands.
    burst_q.push_back(mem[0]);
    start_pulse();
    idle(1);
    rst = 1'b1;
    idle(1);
    check("midrst_nrn_valid", 32'(nrn_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(1);
    check("midrst_burst_q", 32'(burst_q.size()), 32'd0);
    mem[0] = 16'h0A0A; mem[1] = 16'h0B0B; mem[2] = 16'h0C0C; mem[3] = 16'h0D0D;
    push_burst();
    push_res(16'h0009, 16'h0008, 16'h0007);
    start_pulse();
    check("restart_raddr", 32'(in_raddr), 32'd0);
    wait_burst_end();
    pulse(3'b111, 16'h0009, 16'h0008, 16'h0007);
    wait_done(1'b0);

`ifdef LAYER_CTRL_TIMEOUT_EN
    // Neuron 2 never answers: timeout, no results, start while busy ignored.
    push_burst();
    start_pulse();
    wait_burst_end();
    pulse(3'b011, 16'h0001, 16'h0002, 16'h0);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    wait_done(1'b1);
    idle(2);
    check("timeout_no_restart", 32'(busy), 32'd0);
`endif

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
